// File: rtl/barret_1459_pkg.sv
// Shared constants, state encoding and product fold for the mod-1459 multiplier front end.
// The fold maps a 22-bit product into 21 bits without changing its residue mod Q.
package barret_1459_pkg;

   localparam int unsigned Q      = 1459;
   localparam int unsigned W_IN   = 11;
   localparam int unsigned W_OUT  = 21;
   localparam int unsigned W_PROD = 2 * W_IN;
   localparam int unsigned FOLD_K = 2096583;   // 1459*1437, largest multiple of Q below 2^21
   localparam int unsigned CNT_W  = $clog2(W_IN);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      FOLD,
      HOLD
   } state_t;

   // Worst case 4190209 - FOLD_K = 2093626, so the difference always fits in W_OUT bits.
   function automatic logic [W_OUT-1:0] fold_prod(input logic [W_PROD-1:0] p);
      return p[W_PROD-1] ? W_OUT'(p - W_PROD'(FOLD_K)) : p[W_OUT-1:0];
   endfunction

endpackage

// File: rtl/modmul_prep_1459_serial_mul_11.sv
// Serial shift-add multiplier, one multiplier bit per cycle.
// Latency: 11 step cycles after start, then a one-cycle done pulse with product stable.
// Backpressure: none; product holds until the next start.
module serial_mul_11
   import barret_1459_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [W_IN-1:0]   a,
   input  logic [W_IN-1:0]   b,
   output logic              done,
   output logic [W_PROD-1:0] product
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W_IN - 1);

   logic [W_IN-1:0]   mcand;
   logic [W_IN-1:0]   mplier;
   logic [W_PROD-1:0] acc;
   logic [CNT_W-1:0]  cnt;
   logic              busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
         end else if (busy) begin
            // 22-bit accumulator cannot overflow: 2047*2047 < 2^22
            if (mplier[0]) begin
               acc <= acc + ({{(W_PROD-W_IN){1'b0}}, mcand} << cnt);
            end
            mplier <= mplier >> 1;
            if (cnt == LAST_STEP) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   assign product = acc;

endmodule

// File: rtl/modmul_prep_1459.sv
// Multiplies two 11-bit operands and folds the product to 21 bits, same residue mod 1459.
// Latency: out_valid rises 13 edges after accept (11 steps + done register + fold register).
// Backpressure: one operation in flight; dout/out_valid hold while out_ready is low.
module modmul_prep_1459
   import barret_1459_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  a,
   input  logic [W_IN-1:0]  b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OUT-1:0] dout
);

   state_t            state;
   state_t            state_nxt;
   logic              start;
   logic              mul_done;
   logic [W_PROD-1:0] product;

   serial_mul_11 u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         dout  <= '0;
      end else begin
         state <= state_nxt;
         if (state == FOLD) begin
            dout <= fold_prod(product);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               start     = 1'b1;
               state_nxt = MUL;
            end
         end
         MUL:     if (mul_done) state_nxt = FOLD;
         FOLD:    state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_modmul_prep_1459.sv
// Bench for modmul_prep_1459: vector table plus backpressure and mid-operation reset sequences.
// Expected dout values go into a scoreboard queue at accept and are checked at the output handshake.
module tb_modmul_prep_1459;

   typedef struct {
      int a;
      int b;
      int exp_dout;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [10:0] a = '0;
   logic [10:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [20:0] dout;

   int n_checks = 0;
   int n_fail = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   modmul_prep_1459 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_fold(input int av, input int bv);
      int p;
      p = av * bv;
      return (p >= 2097152) ? (p - 2096583) : p;
   endfunction

   // Scoreboard: compare at each output handshake
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         check("scoreboard_nonempty", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("dout", dout, exp_q.pop_front());
      end
   end

   // Called #1 after a rising edge with the DUT idle; returns #1 after the handshake edge.
   task automatic do_op(input int av, input int bv, input int ex, input int hold);
      int n;
      bit busy_ok;
      out_ready = (hold == 0);
      a = 11'(av);
      b = 11'(bv);
      in_valid = 1'b1;
      exp_q.push_back(ex);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 11'($urandom);
      b = 11'($urandom);
      n = 0;
      busy_ok = 1'b1;
      while (!out_valid && n < 40) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      check("latency", n, 13);
      check("in_ready_low_while_busy", busy_ok, 1);
      check("residue", dout % 1459, (av * bv) % 1459);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a = 11'($urandom);
         b = 11'($urandom);
         @(posedge clk); #1;
         check("hold_out_valid", out_valid, 1);
         check("hold_dout", dout, ex);
         check("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_handshake", in_ready, 1);
      check("out_valid_after_handshake", out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      int   seen;
      int   ra;
      int   rb;

      vecs[0] = '{1000, 2, 2000};
      vecs[1] = '{1458, 1458, 29181};
      vecs[2] = '{2047, 2047, 2093626};
      vecs[3] = '{0, 1234, 0};
      vecs[4] = '{1459, 1, 1459};
      vecs[5] = '{1024, 2047, 2096128};

      #1;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_dout", dout, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].exp_dout, 0);
      end

      // Backpressure: five stalled cycles with in_valid pulsing
      do_op(100, 200, 20000, 5);
      seen = 0;
      repeat (16) begin
         @(posedge clk); #1;
         seen |= int'(out_valid);
      end
      check("no_output_from_ignored_in_valid", seen, 0);

      for (int i = 0; i < 4; i++) begin
         ra = int'($urandom_range(0, 2047));
         rb = int'($urandom_range(0, 2047));
         do_op(ra, rb, model_fold(ra, rb), i % 2);
      end

      // Reset during MUL step 5 aborts the operation
      do_op(2047, 1000, 2047000, 0);
      a = 11'd7;
      b = 11'd9;
      in_valid = 1'b1;
      exp_q.push_back(63);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_dout", dout, 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         seen |= int'(out_valid);
      end
      check("no_output_after_abort", seen, 0);
      do_op(3, 5, 15, 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
